// File: rtl/nrzi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nrzi_pkg
//  Description : Shared definitions for the NRZI decoder: the bit-unstuffing
//                FSM state encoding and the stuffing run length.
//  Revision    : 1.0  initial release
// ============================================================================
package nrzi_pkg;

    // One bit of state: DATA shifts data bits, SKIP swallows a stuffed bit.
    typedef enum logic [0:0] {
        DATA = 1'b0,
        SKIP = 1'b1
    } nrzi_state_t;

    // Number of consecutive decoded 1s after which the next bit is stuffed.
    localparam int unsigned STUFF_RUN = 6;

    // Width of the consecutive-ones counter (holds 0..STUFF_RUN-1).
    localparam int unsigned c_ones_w = $clog2(STUFF_RUN);

endpackage
`default_nettype wire

// File: rtl/nrzi_bit_decode.sv
`default_nettype none
// ============================================================================
//  Module      : nrzi_bit_decode
//  Description : NRZI line-level to bit decoder. A line bit equal to the
//                previous level decodes as 1, a transition decodes as 0.
//                Holds the previous-level register.
//  Ports       : clk       - clock, rising edge
//                rst       - asynchronous active-high reset
//                i_bit_en  - accept i_level as a line bit this cycle
//                i_clr     - frame restart, previous level back to idle
//                i_level   - current NRZI line level
//                o_bit     - decoded bit for the current i_level (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module nrzi_bit_decode
    import nrzi_pkg::*;
#(
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_bit_en,
    input  logic i_clr,
    input  logic i_level,
    output logic o_bit
);

    logic r_prev_level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_level <= IDLE_LEVEL;
        end else if (i_clr) begin
            r_prev_level <= IDLE_LEVEL;
        end else if (i_bit_en) begin
            r_prev_level <= i_level;
        end
    end

    assign o_bit = ~(i_level ^ r_prev_level);

endmodule
`default_nettype wire

// File: rtl/nrzi_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : nrzi_decoder
//  Description : NRZI line decoder with LSB-first word assembly, valid/ready
//                output handshake, overrun detection and optional
//                bit-unstuffing (enabled by defining NRZI_DECODER_STUFF_EN).
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset
//                in_valid   - in_level carries a line bit this cycle
//                in_level   - NRZI line level
//                sync_clr   - frame start, aborts any partial word
//                out_data   - decoded word, first received bit in LSB
//                out_valid  - out_data holds an unconsumed word
//                out_ready  - consumer accepts the word when valid && ready
//                stuff_err  - one-cycle pulse on a stuffing violation
//                overrun    - one-cycle pulse when a completed word is dropped
//  Revision    : 1.0  initial release
// ============================================================================
module nrzi_decoder
    import nrzi_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_level,
    input  logic              sync_clr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              stuff_err,
    output logic              overrun
);

    localparam int unsigned         c_cnt_w = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(DATA_W - 1);

    logic                w_accept;
    logic                w_dec;
    logic                w_data_bit;
    logic                w_stuff_viol;
    logic                w_abort;
    logic                w_complete;
    logic [DATA_W-1:0]   w_next_shift;

    logic [DATA_W-1:0]   r_shift;
    logic [c_cnt_w-1:0]  r_count;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_overrun;

    // sync_clr wins over in_valid: the coincident line bit is not consumed.
    assign w_accept = in_valid & ~sync_clr;

    nrzi_bit_decode #(
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_bit_decode (
        .clk      (clk),
        .rst      (rst),
        .i_bit_en (w_accept),
        .i_clr    (sync_clr),
        .i_level  (in_level),
        .o_bit    (w_dec)
    );

`ifdef NRZI_DECODER_STUFF_EN
    localparam logic [c_ones_w-1:0] c_run_last = c_ones_w'(STUFF_RUN - 1);

    nrzi_state_t          r_state;
    logic [c_ones_w-1:0]  r_ones;
    logic                 r_stuff_err;

    assign w_data_bit   = w_accept & (r_state == DATA);
    // A stuffed bit must be a transition; a 1 here means seven 1s in a row.
    assign w_stuff_viol = w_accept & (r_state == SKIP) & w_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= DATA;
            r_ones      <= '0;
            r_stuff_err <= 1'b0;
        end else begin
            r_stuff_err <= 1'b0;
            if (sync_clr) begin
                r_state <= DATA;
                r_ones  <= '0;
            end else if (in_valid) begin
                case (r_state)
                    DATA: begin
                        if (w_dec) begin
                            if (r_ones == c_run_last) begin
                                r_state <= SKIP;
                                r_ones  <= '0;
                            end else begin
                                r_ones <= r_ones + 1'b1;
                            end
                        end else begin
                            r_ones <= '0;
                        end
                    end
                    SKIP: begin
                        r_state <= DATA;
                        r_ones  <= '0;
                        if (w_dec) begin
                            r_stuff_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= DATA;
                        r_ones  <= '0;
                    end
                endcase
            end
        end
    end

    assign stuff_err = r_stuff_err;
`else
    assign w_data_bit   = w_accept;
    assign w_stuff_viol = 1'b0;
    assign stuff_err    = 1'b0;
`endif

    // A stuffing violation drops the partial word like a frame restart, but
    // the line level it carried is still tracked by the bit decoder.
    assign w_abort      = sync_clr | w_stuff_viol;
    assign w_next_shift = {w_dec, r_shift[DATA_W-1:1]};
    assign w_complete   = w_data_bit & (r_count == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_abort) begin
            r_shift <= '0;
            r_count <= '0;
        end else if (w_data_bit) begin
            if (w_complete) begin
                r_shift <= '0;
                r_count <= '0;
            end else begin
                r_shift <= w_next_shift;
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Output holding register. A completed word may replace the held one
    // only if the slot is empty or being consumed in this same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (!r_out_valid || out_ready) begin
                    r_out_data  <= w_next_shift;
                    r_out_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_nrzi_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nrzi_decoder
//  Description : Directed self-checking bench for nrzi_decoder (DATA_W=8,
//                IDLE_LEVEL=1). Line-level vectors are listed LSB-first:
//                bit 0 of each vector is the first level sent.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nrzi_decoder;

    localparam int unsigned DATA_W = 8;

    // Level vectors (first level in bit 0), decoded from a previous level of 1.
    localparam logic [15:0] c_lv_alt  = 16'h00AA; // 0,1,0,1,0,1,0,1 -> 0x00
    localparam logic [15:0] c_lv_a5   = 16'h00C9; // 1,0,0,1,0,0,1,1 -> 0xA5
    localparam logic [15:0] c_lv_0f   = 16'h00AF; // 1,1,1,1,0,1,0,1 -> 0x0F
    localparam logic [15:0] c_lv_ones = 16'h00FF; // eight 1 levels  -> 0xFF
    localparam logic [15:0] c_lv_stf  = 16'h003F; // 1,1,1,1,1,1,0,0,0
    localparam logic [15:0] c_lv_zero = 16'h0000;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_level;
    logic              sync_clr;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              stuff_err;
    logic              overrun;

    int n_cmp;
    int n_fail;
    logic [15:0] lv;

    nrzi_decoder #(
        .DATA_W     (DATA_W),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_level  (in_level),
        .sync_clr  (sync_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stuff_err (stuff_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic level);
        in_valid = 1'b1;
        in_level = level;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_levels(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            send_bit(v[i]);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic pulse_sync(input logic with_bit, input logic level);
        sync_clr = 1'b1;
        in_valid = with_bit;
        in_level = level;
        tick();
        sync_clr = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_level  = 1'b1;
        sync_clr  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_valid",   {31'd0, out_valid}, 32'd0);
        check("rst_data",    {24'd0, out_data},  32'd0);
        check("rst_stufferr", {31'd0, stuff_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun},   32'd0);
        rst = 1'b0;
        tick();

        // Alternating levels: every bit is a transition -> all zeros.
        lv = c_lv_alt;
        send_levels(lv, 7);
        check("alt_valid_7", {31'd0, out_valid}, 32'd0);
        send_bit(lv[7]);
        check("alt_valid_8", {31'd0, out_valid}, 32'd1);
        check("alt_data",    {24'd0, out_data},  32'h00);
        consume();
        check("alt_consumed", {31'd0, out_valid}, 32'd0);

        // Mixed pattern.
        send_levels(c_lv_a5, 8);
        check("a5_valid", {31'd0, out_valid}, 32'd1);
        check("a5_data",  {24'd0, out_data},  32'hA5);
        consume();

        // Two words without consumption: second is dropped with overrun.
        send_levels(c_lv_a5, 8);
        send_levels(c_lv_0f, 8);
        check("ovr_pulse", {31'd0, overrun},   32'd1);
        check("ovr_keep",  {24'd0, out_data},  32'hA5);
        check("ovr_valid", {31'd0, out_valid}, 32'd1);
        tick();
        check("ovr_once",  {31'd0, overrun},   32'd0);
        consume();
        check("ovr_consumed", {31'd0, out_valid}, 32'd0);

        // Handshake and completion in the same cycle: new word replaces old.
        send_levels(c_lv_a5, 8);
        lv = c_lv_0f;
        send_levels(lv, 7);
        out_ready = 1'b1;
        send_bit(lv[7]);
        out_ready = 1'b0;
        check("simul_data",    {24'd0, out_data},  32'h0F);
        check("simul_valid",   {31'd0, out_valid}, 32'd1);
        check("simul_overrun", {31'd0, overrun},   32'd0);
        consume();

        // Asynchronous reset mid-word with a word pending.
        send_levels(c_lv_a5, 8);
        send_levels(c_lv_0f, 4);
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_data",  {24'd0, out_data},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        lv = c_lv_a5;
        send_levels(lv, 7);
        check("arst_no_spurious", {31'd0, out_valid}, 32'd0);
        send_bit(lv[7]);
        check("arst_clean_data",  {24'd0, out_data},  32'hA5);
        check("arst_clean_valid", {31'd0, out_valid}, 32'd1);
        consume();

        // sync_clr with a coincident bit after a 3-bit partial word.
        send_levels(c_lv_zero, 3);
        pulse_sync(1'b1, 1'b0);
        check("sclr_valid", {31'd0, out_valid}, 32'd0);
        send_levels(c_lv_a5, 8);
        check("sclr_data",  {24'd0, out_data},  32'hA5);
        check("sclr_valid2", {31'd0, out_valid}, 32'd1);
        pulse_sync(1'b0, 1'b0);
        check("sclr_keep_valid", {31'd0, out_valid}, 32'd1);
        check("sclr_keep_data",  {24'd0, out_data},  32'hA5);
        consume();

`ifdef NRZI_DECODER_STUFF_EN
        // Six 1s followed by a stuffed transition, then two more 1s.
        pulse_sync(1'b0, 1'b0);
        lv = c_lv_stf;
        send_levels(lv, 8);
        check("stuff_valid_8", {31'd0, out_valid}, 32'd0);
        send_bit(lv[8]);
        check("stuff_data",  {24'd0, out_data},  32'hFF);
        check("stuff_valid", {31'd0, out_valid}, 32'd1);
        check("stuff_noerr", {31'd0, stuff_err}, 32'd0);
        consume();

        // Seven 1s: stuffing violation on the seventh bit.
        pulse_sync(1'b0, 1'b0);
        lv = c_lv_ones;
        send_levels(lv, 6);
        check("viol_before", {31'd0, stuff_err}, 32'd0);
        send_bit(lv[6]);
        check("viol_pulse", {31'd0, stuff_err}, 32'd1);
        check("viol_noword", {31'd0, out_valid}, 32'd0);
        tick();
        check("viol_once", {31'd0, stuff_err}, 32'd0);
        send_levels(c_lv_a5, 8);
        check("viol_after_data",  {24'd0, out_data},  32'hA5);
        check("viol_after_valid", {31'd0, out_valid}, 32'd1);
        consume();
`else
        // Without unstuffing every bit is data, including long runs of 1s.
        send_levels(c_lv_ones, 8);
        check("ones_data",  {24'd0, out_data},  32'hFF);
        check("ones_valid", {31'd0, out_valid}, 32'd1);
        check("ones_noerr", {31'd0, stuff_err}, 32'd0);
        consume();
        check("ones_consumed", {31'd0, out_valid}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nrzi_decoder.md
NRZI_DECODER -- requirements
Module: nrzi_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 8, decoded word width in bits (min 2).
REQ-002 SHALL have parameter IDLE_LEVEL, default 1'b1, line level assumed before the first bit and after sync_clr.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  in_level carries one line bit this cycle.
REQ-006 SHALL have port in_level  input  1  NRZI line level.
REQ-007 SHALL have port sync_clr  input  1  frame start; aborts any partial word.
REQ-008 SHALL have port out_data  output  DATA_W  decoded word, first received bit in LSB.
REQ-009 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the word when out_valid && out_ready.
REQ-011 SHALL have port stuff_err  output  1  one-cycle pulse on a bit-stuffing violation.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when a completed word is dropped.

Function
REQ-013 SHALL decode each accepted bit as ~(in_level ^ prev_level), so no transition gives 1 and a transition gives 0, then update prev_level to in_level.
REQ-014 SHALL shift decoded data bits LSB-first into a DATA_W shift register and count them (0..DATA_W-1).
REQ-015 SHALL, on the cycle the DATA_W-th data bit is accepted, load the complete word into out_data and assert out_valid from the next cycle (1-cycle latency), then restart the count at 0.
REQ-016 SHALL hold out_data and out_valid stable until out_valid && out_ready, and clear out_valid after that handshake unless a new word loads in the same cycle.
REQ-017 SHALL, on simultaneous handshake and word completion, load the new word and keep out_valid at 1 with no overrun.
REQ-018 SHALL, on word completion while out_valid=1 and out_ready=0, keep the old word, discard the new one and pulse overrun for 1 cycle.
REQ-019 SHALL implement the two-state FSM DATA and SKIP: DATA->SKIP after 6 consecutive decoded 1s; SKIP->DATA on the next accepted bit, which is never a data bit.
REQ-020 SHALL ignore in_level and hold all state when in_valid=0.
REQ-021 SHALL let sync_clr take priority over in_valid in the same cycle: clear count, shift register, ones counter and FSM (to DATA), set prev_level=IDLE_LEVEL, and leave out_data, out_valid and pending outputs untouched.

Reset
REQ-022 SHALL, on rst=1 (asynchronous), set out_data=0, out_valid=0, stuff_err=0, overrun=0, prev_level=IDLE_LEVEL, count=0, ones=0, state=DATA.
REQ-023 SHALL lose any partial word when reset arrives mid-word, and deliver no spurious word after rst deasserts.

Configuration
REQ-024 SHALL compile bit-unstuffing only when NRZI_DECODER_STUFF_EN is defined.
REQ-025 SHALL, with the macro defined, discard the SKIP bit if it decodes 0; if it decodes 1, pulse stuff_err, discard the bit and abort the partial word exactly as for sync_clr, except that prev_level is updated.
REQ-026 SHALL, without the macro, omit the SKIP state so every bit is data, and tie stuff_err to 0.

Structure
REQ-027 SHALL place the FSM state enum (DATA, SKIP) and the constant STUFF_RUN=6 in shared package nrzi_pkg.
REQ-028 SHALL isolate the XNOR-based bit decode and prev_level register in sub-module nrzi_bit_decode; shifting, counting, FSM and handshake stay in nrzi_decoder.

Verification
REQ-029 SHALL cover: DATA_W=8, IDLE_LEVEL=1, levels 0,1,0,1,0,1,0,1 -> out_data=0x00, out_valid high 1 cycle after the 8th bit.
REQ-030 SHALL cover: STUFF_EN defined, levels 1,1,1,1,1,1,0,0,0 -> out_data=0xFF after the 9th bit, stuff_err=0.
REQ-031 SHALL cover: STUFF_EN defined, 7 consecutive level-1 bits -> stuff_err pulse on the 7th, no word, count=0.
REQ-032 SHALL cover: out_ready=0, two full words -> first word retained, overrun pulses once, then out_ready=1 -> first word consumed and out_valid=0.
REQ-033 SHALL cover: rst asserted after 4 bits -> all outputs 0 immediately, next 8 bits yield a clean word.
REQ-034 SHALL cover: sync_clr with in_valid after 3 bits -> bit ignored, partial word dropped, prev_level=1.
